// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, field positions and sizing helpers for the FIFO write packer
package fifo_pkg;

  // Packer FSM: FILL accepts beats, HOLD parks a closed word until the slot frees up.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Entry width: packed data lanes, beat-count field (beats-1) and the last flag.
  function automatic int out_bits(input int in_bits, input int ratio);
    return in_bits * ratio + $clog2(ratio) + 1;
  endfunction

  // LSB of the beat-count field sits directly above the data lanes.
  function automatic int cnt_lsb(input int in_bits, input int ratio);
    return in_bits * ratio;
  endfunction

  // The last flag is the MSB of the entry.
  function automatic int last_pos(input int in_bits, input int ratio);
    return out_bits(in_bits, ratio) - 1;
  endfunction

  // Field positions for the default 8-bit x4 configuration.
  localparam int DEF_CNT_LSB  = cnt_lsb(8, 4);
  localparam int DEF_LAST_POS = last_pos(8, 4);

endpackage

// File: rtl/fifo_write_slot.sv
// rtl/fifo_write_slot.sv - single-entry registered output slot feeding the FIFO write port
module fifo_write_slot
  import fifo_pkg::*;
#(
  parameter int W = 35
) (
  input  logic         write_clk,
  input  logic         write_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         p_write_full,
  output logic         out_valid,
  output logic [W-1:0] out_word,
  output logic         accept
);

  logic         valid_q, valid_d;
  logic [W-1:0] word_q, word_d;

  // The slot drains only when the FIFO has room; the word is frozen otherwise.
  assign accept    = valid_q && !p_write_full;
  assign out_valid = valid_q;
  assign out_word  = word_q;

  // Next-state: a load wins over an accept, which is what allows back-to-back words.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (load) begin
      valid_d = 1'b1;
      word_d  = load_word;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers, cleared asynchronously so the write strobe drops at once on reset.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/fifo_write_packer.sv
// rtl/fifo_write_packer.sv - packs narrow beats into FIFO entries and drives the FIFO write port
module fifo_write_packer
  import fifo_pkg::*;
#(
  parameter  int IN_BITS  = 8,
  parameter  int RATIO    = 4,
  parameter  int CNT_W    = 16,
  localparam int OUT_BITS = out_bits(IN_BITS, RATIO)
) (
  input  logic                write_clk,
  input  logic                write_rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_BITS-1:0]  s_data,
  input  logic                s_last,
  input  logic                flush,
  output logic                p_write_en,
  output logic [OUT_BITS-1:0] p_write_data,
  input  logic                p_write_full,
  output logic [CNT_W-1:0]    p_word_count
);

  localparam int LANE_W   = $clog2(RATIO);
  localparam int DATA_W   = IN_BITS * RATIO;
  localparam int CNT_LSB  = cnt_lsb(IN_BITS, RATIO);
  localparam int LAST_POS = last_pos(IN_BITS, RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [LANE_W-1:0]   held_cnt_q, held_cnt_d;
  logic                held_last_q, held_last_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;

  logic                hs;
  logic                slot_free;
  logic                close;
  logic                load;
  logic [OUT_BITS-1:0] load_word;
  logic [DATA_W-1:0]   merged;
  logic [LANE_W-1:0]   close_cnt;
  logic                close_last;
  logic                word_last;
  logic [LANE_W-1:0]   word_cnt;
  logic [DATA_W-1:0]   word_data;
  logic                out_valid;
  logic [OUT_BITS-1:0] out_word;
  logic                accept;

  assign s_ready      = (state_q == FILL);
  assign hs           = s_valid && s_ready;
  assign slot_free    = !out_valid || accept;
  assign p_write_en   = accept;
  assign p_write_data = out_word;
  assign p_word_count = word_cnt_q;

  // Accumulate beats, decide word closure and route closed words to the slot or into HOLD.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    held_cnt_d  = held_cnt_q;
    held_last_d = held_last_q;
    word_cnt_d  = word_cnt_q;
    merged      = acc_q;
    close       = 1'b0;
    close_cnt   = lane_q;
    close_last  = 1'b0;
    load        = 1'b0;
    word_last   = 1'b0;
    word_cnt    = '0;
    word_data   = '0;

    if (accept) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    case (state_q)
      FILL: begin
        if (hs) begin
          for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LANE_W'(k)) begin
              merged[k*IN_BITS +: IN_BITS] = s_data;
            end
          end
          close      = (lane_q == LAST_LANE) || s_last || flush;
          close_cnt  = lane_q;
          close_last = s_last;
        end else if (flush && (lane_q != '0)) begin
          // A standalone flush closes what is already there; no new beat joins the word.
          close     = 1'b1;
          close_cnt = lane_q - LANE_W'(1);
        end

        if (close) begin
          if (slot_free) begin
            load      = 1'b1;
            word_last = close_last;
            word_cnt  = close_cnt;
            word_data = merged;
            lane_d    = '0;
            acc_d     = '0;
          end else begin
            acc_d       = merged;
            held_cnt_d  = close_cnt;
            held_last_d = close_last;
            state_d     = HOLD;
          end
        end else if (hs) begin
          acc_d  = merged;
          lane_d = lane_q + LANE_W'(1);
        end
      end

      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          word_last = held_last_q;
          word_cnt  = held_cnt_q;
          word_data = acc_q;
          lane_d    = '0;
          acc_d     = '0;
          state_d   = FILL;
        end
      end

      default: state_d = FILL;
    endcase

    load_word                      = '0;
    load_word[LAST_POS]            = word_last;
    load_word[CNT_LSB +: LANE_W]   = word_cnt;
    load_word[DATA_W-1:0]          = word_data;
  end

  // Packer state registers; reset discards any partial or held word.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_q     <= FILL;
      lane_q      <= '0;
      acc_q       <= '0;
      held_cnt_q  <= '0;
      held_last_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      held_cnt_q  <= held_cnt_d;
      held_last_q <= held_last_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  fifo_write_slot #(
    .W (OUT_BITS)
  ) u_slot (
    .write_clk    (write_clk),
    .write_rst_n  (write_rst_n),
    .load         (load),
    .load_word    (load_word),
    .p_write_full (p_write_full),
    .out_valid    (out_valid),
    .out_word     (out_word),
    .accept       (accept)
  );

  a_no_write_when_full: assert property (@(posedge write_clk) disable iff (!write_rst_n)
    !(p_write_en && p_write_full));

  a_load_into_free_slot: assert property (@(posedge write_clk) disable iff (!write_rst_n)
    load |-> slot_free);

endmodule

// File: tb/tb_fifo_write_packer.sv
// tb/tb_fifo_write_packer.sv - scoreboard bench for the FIFO write packer
module tb_fifo_write_packer;

  logic        write_clk = 1'b0;
  logic        write_rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        flush = 1'b0;
  logic        p_write_en;
  logic [34:0] p_write_data;
  logic        p_write_full = 1'b0;
  logic [15:0] p_word_count;

  int          checks = 0;
  int          failures = 0;
  logic [34:0] exp_q[$];
  logic [34:0] mon_exp;

  fifo_write_packer #(
    .IN_BITS (8),
    .RATIO   (4),
    .CNT_W   (16)
  ) dut (
    .write_clk    (write_clk),
    .write_rst_n  (write_rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .flush        (flush),
    .p_write_en   (p_write_en),
    .p_write_data (p_write_data),
    .p_write_full (p_write_full),
    .p_word_count (p_word_count)
  );

  initial forever #5 write_clk = ~write_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One beat; returns just after the edge on which it was accepted.
  task automatic beat(input logic [7:0] d, input logic l, input logic f);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    flush   = f;
    @(negedge write_clk);
    while (!s_ready && n < 50) begin
      n++;
      @(negedge write_clk);
    end
    if (!s_ready) begin
      failures++;
      checks++;
      $display("FAIL beat_timeout actual=stalled required=accepted data=%0h", d);
    end
    @(posedge write_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge write_clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge write_clk);
      n++;
    end
    @(posedge write_clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every write the DUT presents is matched against the next expected word.
  always @(negedge write_clk) begin
    if (write_rst_n && p_write_en) begin
      check("write_while_full", 64'(p_write_full), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h required=none", p_write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_data", 64'(p_write_data), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    check("rst_write_en", 64'(p_write_en), 64'd0);
    check("rst_write_data", 64'(p_write_data), 64'd0);
    check("rst_word_count", 64'(p_word_count), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    repeat (2) @(posedge write_clk);
    #1;
    write_rst_n = 1'b1;

    // Full word of four beats, one-cycle write latency
    exp_q.push_back({1'b0, 2'd3, 32'h44332211});
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    beat(8'h33, 1'b0, 1'b0);
    beat(8'h44, 1'b0, 1'b0);
    @(negedge write_clk);
    check("t1_latency_en", 64'(p_write_en), 64'd1);
    @(posedge write_clk);
    #1;
    check("t1_count", 64'(p_word_count), 64'd1);

    // Short packet closed by s_last
    exp_q.push_back({1'b1, 2'd1, 32'h0000BBAA});
    beat(8'hAA, 1'b0, 1'b0);
    beat(8'hBB, 1'b1, 1'b0);
    wait_drain("t2_drain");
    check("t2_count", 64'(p_word_count), 64'd2);

    // Backpressure: pending word in slot, accumulator closes into HOLD
    p_write_full = 1'b1;
    exp_q.push_back({1'b1, 2'd1, 32'h00009190});
    beat(8'h90, 1'b0, 1'b0);
    beat(8'h91, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 2'd3, 32'h04030201});
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0);
    beat(8'h04, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge write_clk);
      check("t3_hold_ready", 64'(s_ready), 64'd0);
      check("t3_hold_en", 64'(p_write_en), 64'd0);
      check("t3_hold_data", 64'(p_write_data), 64'({1'b1, 2'd1, 32'h00009190}));
    end
    @(posedge write_clk);
    #1;
    p_write_full = 1'b0;
    @(negedge write_clk);
    check("t3_drain1_en", 64'(p_write_en), 64'd1);
    check("t3_drain1_ready", 64'(s_ready), 64'd0);
    @(posedge write_clk);
    @(negedge write_clk);
    check("t3_drain2_en", 64'(p_write_en), 64'd1);
    check("t3_drain2_ready", 64'(s_ready), 64'd1);
    @(posedge write_clk);
    #1;
    s_valid = 1'b0;
    exp_q.push_back({1'b0, 2'd0, 32'h00000005});
    do_flush();
    wait_drain("t3_drain");
    check("t3_count", 64'(p_word_count), 64'd5);

    // Flush of a partial word, then a flush with nothing to close
    exp_q.push_back({1'b0, 2'd2, 32'h00030201});
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0);
    do_flush();
    wait_drain("t4_drain");
    check("t4_count", 64'(p_word_count), 64'd6);
    do_flush();
    repeat (3) @(posedge write_clk);
    #1;
    check("t4_empty_flush_count", 64'(p_word_count), 64'd6);

    // flush and s_last together make a single word
    exp_q.push_back({1'b1, 2'd1, 32'h00005A10});
    beat(8'h10, 1'b0, 1'b0);
    beat(8'h5A, 1'b1, 1'b1);
    wait_drain("t5_drain");
    repeat (3) @(posedge write_clk);
    #1;
    check("t5_count", 64'(p_word_count), 64'd7);

    // Mid-operation reset with a pending write and a partial word
    p_write_full = 1'b1;
    beat(8'hE0, 1'b0, 1'b0);
    beat(8'hE1, 1'b0, 1'b0);
    beat(8'hE2, 1'b0, 1'b0);
    beat(8'hE3, 1'b0, 1'b0);
    beat(8'hC8, 1'b0, 1'b0);
    beat(8'hC9, 1'b0, 1'b0);
    p_write_full = 1'b0;
    #1;
    check("t6_pre_reset_en", 64'(p_write_en), 64'd1);
    #1;
    write_rst_n = 1'b0;
    #1;
    check("t6_reset_en", 64'(p_write_en), 64'd0);
    check("t6_reset_count", 64'(p_word_count), 64'd0);
    check("t6_reset_ready", 64'(s_ready), 64'd1);
    check("t6_reset_data", 64'(p_write_data), 64'd0);
    repeat (2) @(posedge write_clk);
    #1;
    write_rst_n = 1'b1;
    exp_q.push_back({1'b0, 2'd3, 32'hC3C2C1C0});
    beat(8'hC0, 1'b0, 1'b0);
    beat(8'hC1, 1'b0, 1'b0);
    beat(8'hC2, 1'b0, 1'b0);
    beat(8'hC3, 1'b0, 1'b0);
    wait_drain("t6_drain");
    check("t6_count", 64'(p_word_count), 64'd1);

    repeat (2) @(posedge write_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
